// File: rtl/reg_apb_access_ctrl.sv
// APB3 slave front-end for a flat bank of 32-bit field registers.
// Decodes the word index, inserts wait states, registers read data and issues one-cycle strobes.
module reg_apb_access_ctrl #(
  parameter int                 ADDR_WIDTH  = 12,
  parameter int                 DATA_WIDTH  = 32,
  parameter int                 REG_NUM     = 8,
  parameter int                 WAIT_CYCLES = 0,
  parameter logic [REG_NUM-1:0] RO_MASK     = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          psel,
  input  logic                          penable,
  input  logic                          pwrite,
  input  logic [ADDR_WIDTH-1:0]         paddr,
  input  logic [DATA_WIDTH-1:0]         pwdata,
  output logic                          pready,
  output logic [DATA_WIDTH-1:0]         prdata,
  output logic                          pslverr,
  output logic [REG_NUM-1:0]            reg_wr_en,
  output logic [DATA_WIDTH-1:0]         reg_wr_data,
  output logic [REG_NUM-1:0]            reg_rd_strobe,
  input  logic [REG_NUM*DATA_WIDTH-1:0] reg_rd_data
);

  localparam int         IDX_W    = ADDR_WIDTH - 2;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  wr_q, wr_d;
  logic                  err_q, err_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

  logic                  setup;
  logic                  access;
  logic [IDX_W-1:0]      addr_idx;
  logic [IDX_W-1:0]      sel_idx;
  logic                  sel_err;
  logic                  in_range;
  logic                  ro_hit;
  logic                  dec_err;
  logic [DATA_WIDTH-1:0] rd_mux;

  assign setup    = (state_q == S_IDLE) && psel && !penable;
  assign access   = (state_q == S_RESP) && psel && penable;
  assign addr_idx = paddr[ADDR_WIDTH-1:2];
  // On a zero-wait access the read mux must see the index being latched this cycle.
  assign sel_idx  = setup ? addr_idx : idx_q;

  always_comb begin
    in_range = 1'b0;
    ro_hit   = 1'b0;
    rd_mux   = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (addr_idx == IDX_W'(i)) begin
        in_range = 1'b1;
        ro_hit   = RO_MASK[i];
      end
      if (sel_idx == IDX_W'(i)) begin
        rd_mux = reg_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign dec_err = (paddr[1:0] != 2'b00) || !in_range || (pwrite && ro_hit);
  assign sel_err = setup ? dec_err : err_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    wr_d     = wr_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    wdata_d  = wdata_q;
    prdata_d = prdata_q;
    case (state_q)
      S_IDLE: begin
        if (setup) begin
          idx_d   = addr_idx;
          wr_d    = pwrite;
          err_d   = dec_err;
          wdata_d = pwdata;
          cnt_d   = CNT_INIT;
          state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!psel) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_RESP && state_q != S_RESP) begin
      prdata_d = sel_err ? '0 : rd_mux;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      wdata_q  <= '0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      wdata_q  <= wdata_d;
      prdata_q <= prdata_d;
    end
  end

  always_comb begin
    reg_wr_en     = '0;
    reg_rd_strobe = '0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (access && !err_q && idx_q == IDX_W'(i)) begin
        if (wr_q) reg_wr_en[i]     = 1'b1;
        else      reg_rd_strobe[i] = 1'b1;
      end
    end
  end

  assign pready      = access;
  assign pslverr     = access && err_q;
  assign prdata      = prdata_q;
  assign reg_wr_data = wdata_q;

endmodule

// File: tb/tb_reg_apb_access_ctrl.sv
// Bench for reg_apb_access_ctrl: three instances (0, 3 and 2 wait states) share one APB bus;
// dsel picks which instance's responses are scored.
module tb_reg_apb_access_ctrl;

  localparam int NDUT = 3;

  typedef struct packed {
    logic [3:0]  lat;
    logic        slverr;
    logic [31:0] rdata;
    logic [7:0]  wr_en;
    logic [7:0]  rd_stb;
    logic [31:0] wr_data;
  } resp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         psel = 1'b0;
  logic         penable = 1'b0;
  logic         pwrite = 1'b0;
  logic [11:0]  paddr = '0;
  logic [31:0]  pwdata = '0;
  logic [255:0] reg_rd_data;
  logic [31:0]  regval [8];

  logic        pready_v  [NDUT];
  logic        pslverr_v [NDUT];
  logic [31:0] prdata_v  [NDUT];
  logic [31:0] wr_data_v [NDUT];
  logic [7:0]  wr_en_v   [NDUT];
  logic [7:0]  rd_stb_v  [NDUT];

  int          dsel = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  resp_t       exp_q[$];

  logic        cur_pready, cur_pslverr;
  logic [31:0] cur_prdata, cur_wr_data;
  logic [7:0]  cur_wr_en, cur_rd_stb;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 8; g++) begin : g_rd
    assign reg_rd_data[g*32 +: 32] = regval[g];
  end

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    reg_apb_access_ctrl #(
      .ADDR_WIDTH (12),
      .DATA_WIDTH (32),
      .REG_NUM    (8),
      .WAIT_CYCLES(g == 0 ? 0 : (g == 1 ? 3 : 2)),
      .RO_MASK    (8'h04)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .psel         (psel),
      .penable      (penable),
      .pwrite       (pwrite),
      .paddr        (paddr),
      .pwdata       (pwdata),
      .pready       (pready_v[g]),
      .prdata       (prdata_v[g]),
      .pslverr      (pslverr_v[g]),
      .reg_wr_en    (wr_en_v[g]),
      .reg_wr_data  (wr_data_v[g]),
      .reg_rd_strobe(rd_stb_v[g]),
      .reg_rd_data  (reg_rd_data)
    );
  end

  assign cur_pready  = pready_v[dsel];
  assign cur_pslverr = pslverr_v[dsel];
  assign cur_prdata  = prdata_v[dsel];
  assign cur_wr_data = wr_data_v[dsel];
  assign cur_wr_en   = wr_en_v[dsel];
  assign cur_rd_stb  = rd_stb_v[dsel];

  task automatic idle(input int n);
    psel    = 1'b0;
    penable = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the completing edge with psel still high.
  task automatic apb_access(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                            output resp_t obs, output bit got);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(negedge clk);
    penable = 1'b1;
    got = 1'b0;
    obs = '0;
    for (int c = 1; c <= 20; c++) begin
      #1;
      if (cur_pready) begin
        obs.lat     = 4'(c);
        obs.slverr  = cur_pslverr;
        obs.rdata   = wr ? 32'h0 : cur_prdata;
        obs.wr_en   = cur_wr_en;
        obs.rd_stb  = cur_rd_stb;
        obs.wr_data = wr ? cur_wr_data : 32'h0;
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      n_checks++;
      if ({pready_v[d], pslverr_v[d], prdata_v[d], wr_en_v[d], rd_stb_v[d], wr_data_v[d]} !== '0)
        $display("FAIL reset_dut%0d: got pready=%b pslverr=%b prdata=%h wr_en=%h rd_stb=%h wr_data=%h, want all 0",
                 d, pready_v[d], pslverr_v[d], prdata_v[d], wr_en_v[d], rd_stb_v[d], wr_data_v[d]);
      else n_pass++;
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_nowait();
    resp_t obs, want;
    bit    got;
    dsel = 0;
    idle(2);
    exp_q.push_back(resp_t'{4'd1, 1'b0, 32'h0, 8'h02, 8'h00, 32'hA5A5_0001});
    apb_access(1'b1, 12'h004, 32'hA5A5_0001, obs, got);
    want = exp_q.pop_front();
    n_checks++;
    if (!got) $display("FAIL wr_nowait: no pready within 20 cycles");
    else if (obs !== want) $display("FAIL wr_nowait: got %h want %h", obs, want);
    else n_pass++;
    #1;
    n_checks++;
    if (cur_wr_en !== 8'h00 || cur_wr_data !== 32'hA5A5_0001)
      $display("FAIL wr_pulse_hold: wr_en=%h wr_data=%h, want 00 / a5a50001", cur_wr_en, cur_wr_data);
    else n_pass++;
    @(negedge clk);
    idle(1);
  endtask

  task automatic test_read_wait();
    resp_t obs, want;
    bit    got;
    dsel = 1;
    idle(4);
    exp_q.push_back(resp_t'{4'd4, 1'b0, 32'h1234_5678, 8'h00, 8'h80, 32'h0});
    apb_access(1'b0, 12'h01C, 32'h0, obs, got);
    want = exp_q.pop_front();
    n_checks++;
    if (!got) $display("FAIL rd_wait3: no pready within 20 cycles");
    else if (obs !== want) $display("FAIL rd_wait3: got %h want %h", obs, want);
    else n_pass++;
    idle(1);
  endtask

  task automatic test_ro_error();
    resp_t obs, want;
    bit    got;
    dsel = 0;
    idle(4);
    exp_q.push_back(resp_t'{4'd1, 1'b1, 32'h0, 8'h00, 8'h00, 32'h5555_AAAA});
    exp_q.push_back(resp_t'{4'd1, 1'b0, regval[2], 8'h00, 8'h04, 32'h0});
    apb_access(1'b1, 12'h008, 32'h5555_AAAA, obs, got);
    want = exp_q.pop_front();
    n_checks++;
    if (!got) $display("FAIL ro_write: no pready within 20 cycles");
    else if (obs !== want) $display("FAIL ro_write: got %h want %h", obs, want);
    else n_pass++;
    idle(1);
    apb_access(1'b0, 12'h008, 32'h0, obs, got);
    want = exp_q.pop_front();
    n_checks++;
    if (!got) $display("FAIL ro_read: no pready within 20 cycles");
    else if (obs !== want) $display("FAIL ro_read: got %h want %h", obs, want);
    else n_pass++;
    idle(1);
  endtask

  task automatic test_decode_error();
    logic [11:0] addrs [3];
    logic        wrs   [3];
    resp_t       obs, want;
    bit          got;
    addrs = '{12'h020, 12'h005, 12'h3FC};
    wrs   = '{1'b0, 1'b0, 1'b1};
    dsel = 0;
    idle(2);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(resp_t'{4'd1, 1'b1, 32'h0, 8'h00, 8'h00, wrs[k] ? 32'h7777_0000 : 32'h0});
      apb_access(wrs[k], addrs[k], 32'h7777_0000, obs, got);
      want = exp_q.pop_front();
      n_checks++;
      if (!got) $display("FAIL dec_err_%h: no pready within 20 cycles", addrs[k]);
      else if (obs !== want) $display("FAIL dec_err_%h: got %h want %h", addrs[k], obs, want);
      else n_pass++;
      idle(1);
    end
  endtask

  task automatic test_reset_mid();
    resp_t obs, want;
    bit    got;
    dsel = 2;
    idle(4);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h010; pwdata = 32'hDEAD_BEEF;
    @(negedge clk);
    penable = 1'b1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (cur_pready !== 1'b0 || cur_wr_en !== 8'h00 || cur_wr_data !== 32'h0)
      $display("FAIL rst_mid: pready=%b wr_en=%h wr_data=%h, want 0/00/0", cur_pready, cur_wr_en, cur_wr_data);
    else n_pass++;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; rst = 1'b0;
    @(negedge clk);
    exp_q.push_back(resp_t'{4'd3, 1'b0, 32'h0, 8'h10, 8'h00, 32'h0BAD_F00D});
    apb_access(1'b1, 12'h010, 32'h0BAD_F00D, obs, got);
    want = exp_q.pop_front();
    n_checks++;
    if (!got) $display("FAIL rst_recover: no pready within 20 cycles");
    else if (obs !== want) $display("FAIL rst_recover: got %h want %h", obs, want);
    else n_pass++;
    idle(1);
  endtask

  task automatic test_back_to_back();
    resp_t obs, want;
    bit    got;
    logic  noisy;
    dsel = 1;
    idle(4);
    exp_q.push_back(resp_t'{4'd4, 1'b0, regval[0], 8'h00, 8'h01, 32'h0});
    exp_q.push_back(resp_t'{4'd4, 1'b0, 32'h0, 8'h08, 8'h00, 32'hCAFE_0003});
    apb_access(1'b0, 12'h000, 32'h0, obs, got);
    want = exp_q.pop_front();
    n_checks++;
    if (!got) $display("FAIL b2b_read: no pready within 20 cycles");
    else if (obs !== want) $display("FAIL b2b_read: got %h want %h", obs, want);
    else n_pass++;
    apb_access(1'b1, 12'h00C, 32'hCAFE_0003, obs, got);
    want = exp_q.pop_front();
    n_checks++;
    if (!got) $display("FAIL b2b_write: no pready within 20 cycles");
    else if (obs !== want) $display("FAIL b2b_write: got %h want %h", obs, want);
    else n_pass++;
    // Third access abandoned mid-WAIT.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h014; pwdata = 32'hBEEF_0005;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    noisy = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (cur_pready || cur_wr_en != 8'h00 || cur_rd_stb != 8'h00) noisy = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (noisy !== 1'b0) $display("FAIL abort_quiet: activity seen=%b, want 0", noisy);
    else n_pass++;
    exp_q.push_back(resp_t'{4'd4, 1'b0, 32'h1234_5678, 8'h00, 8'h80, 32'h0});
    apb_access(1'b0, 12'h01C, 32'h0, obs, got);
    want = exp_q.pop_front();
    n_checks++;
    if (!got) $display("FAIL after_abort: no pready within 20 cycles");
    else if (obs !== want) $display("FAIL after_abort: got %h want %h", obs, want);
    else n_pass++;
    idle(1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) regval[i] = 32'hC0DE_0000 + 32'(i);
    regval[7] = 32'h1234_5678;
    test_reset();
    test_write_nowait();
    test_read_wait();
    test_ro_error();
    test_decode_error();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
